alu_op_sequencer: RTL and testbench

Command-level controller for the shared ALU datapath. It accepts one operation at a time from a requester over a valid/ready handshake and latches the operands and function code. It drives them into the ALU and waits for the class flag of the selected unit. It then captures and formats the result and holds it until the consumer accepts it. Between operations it deasserts the ALU enable so the clock-gating cell can stop the ALU clock.

---
 rtl/alu_op_sequencer_if.sv | 54 +++++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command, ALU and result signal bundle for alu_op_sequencer
//
// Purpose: groups the requester handshake, the ALU drive/return signals and the
// result handshake into one bundle.
// Modports:
//   slave  - the sequencer: takes commands and ALU returns, drives ALU inputs and result
//   master - the environment: requester, ALU model and result consumer
interface alu_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             CMD_VLD;
  logic             CMD_RDY;
  logic [3:0]       CMD_FUN;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;

  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic [3:0]       ALU_FUN;
  logic             ALU_EN;
  logic [WIDTH-1:0] ALU_ARITH;
  logic             ALU_CARRY;
  logic [WIDTH:0]   ALU_LOGIC;
  logic [1:0]       ALU_CMP;
  logic [WIDTH-1:0] ALU_SHIFT;
  logic             ALU_ARITH_FLG;
  logic             ALU_LOGIC_FLG;
  logic             ALU_CMP_FLG;
  logic             ALU_SHIFT_FLG;

  logic [WIDTH:0]   RES_DATA;
  logic             RES_ERR;
  logic             RES_VLD;
  logic             RES_RDY;
  logic             BUSY;

  modport slave (
    input  CMD_VLD, CMD_FUN, CMD_A, CMD_B,
    input  ALU_ARITH, ALU_CARRY, ALU_LOGIC, ALU_CMP, ALU_SHIFT,
    input  ALU_ARITH_FLG, ALU_LOGIC_FLG, ALU_CMP_FLG, ALU_SHIFT_FLG,
    input  RES_RDY,
    output CMD_RDY, ALU_A, ALU_B, ALU_FUN, ALU_EN,
    output RES_DATA, RES_ERR, RES_VLD, BUSY
  );

  modport master (
    output CMD_VLD, CMD_FUN, CMD_A, CMD_B,
    output ALU_ARITH, ALU_CARRY, ALU_LOGIC, ALU_CMP, ALU_SHIFT,
    output ALU_ARITH_FLG, ALU_LOGIC_FLG, ALU_CMP_FLG, ALU_SHIFT_FLG,
    output RES_RDY,
    input  CMD_RDY, ALU_A, ALU_B, ALU_FUN, ALU_EN,
    input  RES_DATA, RES_ERR, RES_VLD, BUSY
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time command sequencer for the shared ALU
//
// Purpose: accepts a command, drives the latched operands into the ALU, waits
// (bounded by MAX_WAIT cycles) for the selected class flag, then holds a
// formatted result (or a timeout marker) until the consumer takes it.
// Ports:
//   CLK - system clock
//   RST - asynchronous active-low reset
//   bus - alu_op_sequencer_if.slave (command, ALU and result signals)
module alu_op_sequencer #(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_op_sequencer_if.slave    bus
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_fun_q;
  logic             alu_en_q;
  logic [WIDTH:0]   res_data_q;
  logic             res_err_q;
  logic             res_vld_q;
  logic             busy_q;

  logic             flag_d;
  logic [WIDTH:0]   res_fmt_d;

  // Class is taken from the latched function code, never from CMD_FUN, so the
  // other classes' flags cannot end the wait early.
  always_comb begin
    flag_d    = 1'b0;
    res_fmt_d = '0;
    unique case (alu_fun_q[3:2])
      2'b00: begin
        flag_d    = bus.ALU_ARITH_FLG;
        res_fmt_d = {bus.ALU_CARRY, bus.ALU_ARITH};
      end
      2'b01: begin
        flag_d    = bus.ALU_LOGIC_FLG;
        res_fmt_d = bus.ALU_LOGIC;
      end
      2'b10: begin
        flag_d    = bus.ALU_CMP_FLG;
        res_fmt_d = {{(WIDTH-1){1'b0}}, bus.ALU_CMP};
      end
      default: begin
        flag_d    = bus.ALU_SHIFT_FLG;
        res_fmt_d = {1'b0, bus.ALU_SHIFT};
      end
    endcase
  end

  // Outputs are registered and updated on state entry so ALU_EN is glitch-free
  // and ALU_A/ALU_B/ALU_FUN only move when a command is accepted.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_fun_q  <= '0;
      alu_en_q   <= 1'b0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.CMD_VLD) begin
            alu_a_q   <= bus.CMD_A;
            alu_b_q   <= bus.CMD_B;
            alu_fun_q <= bus.CMD_FUN;
            alu_en_q  <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (flag_d) begin
            res_data_q <= res_fmt_d;
            res_err_q  <= 1'b0;
            res_vld_q  <= 1'b1;
            alu_en_q   <= 1'b0;
            state_q    <= HOLD;
          end else if (cnt_q == CNT_LAST) begin
            res_data_q <= '0;
            res_err_q  <= 1'b1;
            res_vld_q  <= 1'b1;
            alu_en_q   <= 1'b0;
            state_q    <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (bus.RES_RDY) begin
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.CMD_RDY  = (state_q == IDLE);
  assign bus.ALU_A    = alu_a_q;
  assign bus.ALU_B    = alu_b_q;
  assign bus.ALU_FUN  = alu_fun_q;
  assign bus.ALU_EN   = alu_en_q;
  assign bus.RES_DATA = res_data_q;
  assign bus.RES_ERR  = res_err_q;
  assign bus.RES_VLD  = res_vld_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(.WIDTH(16), .MAX_WAIT(4)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flg = {arith, logic, cmp, shift}; lat counts rising edges, accept edge = 1
  typedef struct {
    logic [3:0]  fun;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] arith;
    logic        carry;
    logic [16:0] logic_r;
    logic [1:0]  cmp;
    logic [15:0] shift;
    logic [3:0]  flg;
    logic [16:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_alu(input logic [15:0] arith, input logic carry, input logic [16:0] lg,
                         input logic [1:0] cmp, input logic [15:0] shift, input logic [3:0] flg);
    bus.ALU_ARITH     = arith;
    bus.ALU_CARRY     = carry;
    bus.ALU_LOGIC     = lg;
    bus.ALU_CMP       = cmp;
    bus.ALU_SHIFT     = shift;
    bus.ALU_ARITH_FLG = flg[3];
    bus.ALU_LOGIC_FLG = flg[2];
    bus.ALU_CMP_FLG   = flg[1];
    bus.ALU_SHIFT_FLG = flg[0];
  endtask

  // Waits for RES_VLD after the accept edge; returns edge count incl. accept edge.
  task automatic wait_res(output int n);
    n = 1;
    while (bus.RES_VLD !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] fun, input logic [15:0] a,
                        input logic [15:0] b, input logic [16:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int n;
    bus.RES_RDY = 1'b1;
    @(negedge clk);
    chk({tag, "_cmd_rdy_idle"}, bus.CMD_RDY, 1);
    bus.CMD_FUN = fun;
    bus.CMD_A   = a;
    bus.CMD_B   = b;
    bus.CMD_VLD = 1'b1;
    @(posedge clk); #1;
    bus.CMD_VLD = 1'b0;
    chk({tag, "_issue_en"}, bus.ALU_EN, 1);
    chk({tag, "_issue_a"}, bus.ALU_A, a);
    chk({tag, "_issue_b"}, bus.ALU_B, b);
    chk({tag, "_issue_fun"}, bus.ALU_FUN, fun);
    chk({tag, "_issue_busy"}, bus.BUSY, 1);
    chk({tag, "_issue_cmd_rdy"}, bus.CMD_RDY, 0);
    wait_res(n);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_res_vld"}, bus.RES_VLD, 1);
    chk({tag, "_res_data"}, bus.RES_DATA, exp_data);
    chk({tag, "_res_err"}, bus.RES_ERR, exp_err);
    chk({tag, "_hold_en"}, bus.ALU_EN, 0);
    @(posedge clk); #1;
    chk({tag, "_ret_cmd_rdy"}, bus.CMD_RDY, 1);
    chk({tag, "_ret_res_vld"}, bus.RES_VLD, 0);
    chk({tag, "_ret_busy"}, bus.BUSY, 0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;

    vecs[0] = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 17'h0, 2'b00, 16'h0, 4'b1000, 17'h10000, 1'b0, 3};
    vecs[1] = '{4'b1001, 16'h0005, 16'h0003, 16'hABCD, 1'b1, 17'h0, 2'b10, 16'h0, 4'b1010, 17'h00002, 1'b0, 3};
    vecs[2] = '{4'b0110, 16'h00FF, 16'h0F0F, 16'h0, 1'b0, 17'h12345, 2'b00, 16'h0, 4'b0100, 17'h12345, 1'b0, 3};
    vecs[3] = '{4'b1100, 16'h4000, 16'h0001, 16'h0, 1'b0, 17'h0, 2'b00, 16'h8001, 4'b0001, 17'h08001, 1'b0, 3};
    vecs[4] = '{4'b0100, 16'h1234, 16'h5678, 16'h1111, 1'b1, 17'h1FFFF, 2'b11, 16'h2222, 4'b1011, 17'h00000, 1'b1, 6};
    vecs[5] = '{4'b0001, 16'h2000, 16'h0DCC, 16'h1234, 1'b0, 17'h0, 2'b00, 16'h0, 4'b1000, 17'h01234, 1'b0, 3};
    vecs[6] = '{4'b1000, 16'hBEEF, 16'hCAFE, 16'h5555, 1'b1, 17'h0, 2'b01, 16'h3333, 4'b0101, 17'h00000, 1'b1, 6};

    // Reset state
    rst_n = 1'b0;
    bus.CMD_VLD = 1'b0;
    bus.CMD_FUN = 4'h0;
    bus.CMD_A   = 16'h0;
    bus.CMD_B   = 16'h0;
    bus.RES_RDY = 1'b0;
    set_alu(16'h0, 1'b0, 17'h0, 2'b00, 16'h0, 4'b0000);
    #2;
    chk("rst_cmd_rdy", bus.CMD_RDY, 1);
    chk("rst_alu_en", bus.ALU_EN, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_res_vld", bus.RES_VLD, 0);
    chk("rst_res_data", bus.RES_DATA, 0);
    chk("rst_alu_a", bus.ALU_A, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 7; i++) begin
      set_alu(vecs[i].arith, vecs[i].carry, vecs[i].logic_r, vecs[i].cmp, vecs[i].shift, vecs[i].flg);
      run_op($sformatf("v%0d", i), vecs[i].fun, vecs[i].a, vecs[i].b,
             vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Idle gating: CMD_A/CMD_B toggle with CMD_VLD=0, ALU inputs must not follow
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.CMD_A = 16'h0F0F ^ 16'(i * 16'h1111);
      bus.CMD_B = ~bus.CMD_A;
      @(posedge clk); #1;
      chk($sformatf("idle%0d_alu_a", i), bus.ALU_A, 16'hBEEF);
      chk($sformatf("idle%0d_alu_b", i), bus.ALU_B, 16'hCAFE);
      chk($sformatf("idle%0d_alu_en", i), bus.ALU_EN, 0);
    end

    // Back-pressure on a shift result, with a second command waiting
    bus.RES_RDY = 1'b0;
    set_alu(16'h0, 1'b0, 17'h0, 2'b00, 16'h00F0, 4'b0001);
    @(negedge clk);
    bus.CMD_FUN = 4'b1101;
    bus.CMD_A   = 16'h0010;
    bus.CMD_B   = 16'h0004;
    bus.CMD_VLD = 1'b1;
    @(posedge clk); #1;
    bus.CMD_VLD = 1'b0;
    wait_res(n);
    chk("bp_latency", n, 3);
    chk("bp_res_data", bus.RES_DATA, 17'h000F0);
    bus.CMD_FUN = 4'b0000;
    bus.CMD_A   = 16'h7777;
    bus.CMD_B   = 16'h0001;
    bus.CMD_VLD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_vld", i), bus.RES_VLD, 1);
      chk($sformatf("bp%0d_data", i), bus.RES_DATA, 17'h000F0);
      chk($sformatf("bp%0d_en", i), bus.ALU_EN, 0);
      chk($sformatf("bp%0d_cmd_rdy", i), bus.CMD_RDY, 0);
      chk($sformatf("bp%0d_alu_a", i), bus.ALU_A, 16'h0010);
    end
    @(negedge clk);
    bus.RES_RDY = 1'b1;
    set_alu(16'h0042, 1'b0, 17'h0, 2'b00, 16'h00F0, 4'b1000);
    @(posedge clk); #1;
    chk("bp_release_cmd_rdy", bus.CMD_RDY, 1);
    chk("bp_release_busy", bus.BUSY, 0);
    chk("bp_release_vld", bus.RES_VLD, 0);
    chk("bp_release_alu_a", bus.ALU_A, 16'h0010);
    @(posedge clk); #1;
    bus.CMD_VLD = 1'b0;
    chk("bp_second_busy", bus.BUSY, 1);
    chk("bp_second_alu_a", bus.ALU_A, 16'h7777);
    chk("bp_second_en", bus.ALU_EN, 1);
    wait_res(n);
    chk("bp_second_latency", n, 3);
    chk("bp_second_data", bus.RES_DATA, 17'h00042);
    @(posedge clk); #1;
    chk("bp_second_ret_cmd_rdy", bus.CMD_RDY, 1);

    // Reset asserted during WAIT
    set_alu(16'h0, 1'b0, 17'h0, 2'b00, 16'h0, 4'b0000);
    @(negedge clk);
    bus.CMD_FUN = 4'b0010;
    bus.CMD_A   = 16'h1111;
    bus.CMD_B   = 16'h2222;
    bus.CMD_VLD = 1'b1;
    @(posedge clk); #1;
    bus.CMD_VLD = 1'b0;
    @(posedge clk); #1;
    chk("rmid_wait_en", bus.ALU_EN, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid_alu_en", bus.ALU_EN, 0);
    chk("rmid_alu_a", bus.ALU_A, 0);
    chk("rmid_alu_b", bus.ALU_B, 0);
    chk("rmid_alu_fun", bus.ALU_FUN, 0);
    chk("rmid_busy", bus.BUSY, 0);
    chk("rmid_res_vld", bus.RES_VLD, 0);
    chk("rmid_res_err", bus.RES_ERR, 0);
    chk("rmid_res_data", bus.RES_DATA, 0);
    chk("rmid_cmd_rdy", bus.CMD_RDY, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rmid_after_vld", bus.RES_VLD, 0);
    chk("rmid_after_busy", bus.BUSY, 0);
    set_alu(16'h0005, 1'b0, 17'h0, 2'b00, 16'h0, 4'b1000);
    run_op("rmid_next", 4'b0000, 16'h0002, 16'h0003, 17'h00005, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
